bsg_cache_dma_arbiter: RTL and testbench
========================================

# bsg_cache_dma_arbiter

Shares a single memory-side DMA channel among `num_cache_p` cache DMA ports, each of which carries a `bsg_cache_dma_pkt_s` packet stream, an outbound write-data stream and an inbound fill-data stream. Packets are granted round-robin. Write bursts are locked to their owner until the last beat. Read-return beats are routed back to requesters in grant order through an ID FIFO. The block sits between the caches' DMA engines and the memory controller or network adapter.

## Interface
Parameters:
- `num_cache_p`, none (required), number of cache ports, ≥2.
- `addr_width_p`, none (required), DMA packet address width.
- `block_size_in_words_p`, none (required), cache block size in words.
- `ways_p`, none (required), associativity; with the two above, sizes the packet via `bsg_cache_dma_pkt_width`.
- `dma_data_width_p`, none (required), beat width.
- `burst_len_p`, none (required), beats per block; must be ≥1.
- `read_fifo_els_p`, 4, maximum number of outstanding reads.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `dma_pkt_i`  in  num_cache_p×pkt_width  per-cache packets.
- `dma_pkt_v_i`  in  num_cache_p  packet valid.
- `dma_pkt_yumi_o`  out  num_cache_p  packet consumed.
- `dma_data_i`  in  num_cache_p×dma_data_width_p  per-cache write data.
- `dma_data_v_i`  in  num_cache_p  write data valid.
- `dma_data_yumi_o`  out  num_cache_p  write data consumed.
- `dma_data_o`  out  num_cache_p×dma_data_width_p  fill data, broadcast to all ports.
- `dma_data_v_o`  out  num_cache_p  fill data valid, one-hot.
- `dma_data_ready_and_i`  in  num_cache_p  cache ready for fill data.
- `mem_pkt_o`, `mem_pkt_v_o` out; `mem_pkt_ready_and_i` in: memory packet channel, valid/ready.
- `mem_wdata_o`, `mem_wdata_v_o` out; `mem_wdata_ready_and_i` in: memory write-data channel.
- `mem_rdata_i`, `mem_rdata_v_i` in; `mem_rdata_ready_and_o` out: memory read-return channel.

## Operation
- Write FSM:
  - IDLE: the arbiter picks one requester among `dma_pkt_v_i` and drives `mem_pkt_o`/`mem_pkt_v_o` from it.
  - A read packet (`write_not_read=0`) is eligible only when the ID FIFO is not full.
  - On handshake (`mem_pkt_v_o & mem_pkt_ready_and_i`), the arbiter asserts `dma_pkt_yumi_o[g]`.
  - A read handshake pushes `g` into the ID FIFO.
  - A write handshake latches `wid_r=g`, clears `wcnt_r`, and moves the FSM to SEND_WDATA.
- SEND_WDATA: no packets are granted.
  - `mem_wdata_o=dma_data_i[wid_r]`, `mem_wdata_v_o=dma_data_v_i[wid_r]`, `dma_data_yumi_o[wid_r]=mem_wdata_v_o & mem_wdata_ready_and_i`.
  - `wcnt_r` increments per beat. On beat `burst_len_p-1`, the counter clears and the FSM returns to IDLE.
- Round-robin pointer: after every packet handshake, the pointer becomes `g+1`, wrapping to 0 after `num_cache_p-1`. The pointer holds when no handshake occurs.
- Read return:
  - With `rid = FIFO head`: `dma_data_v_o[rid]=mem_rdata_v_i & ~fifo_empty`, `mem_rdata_ready_and_o=~fifo_empty & dma_data_ready_and_i[rid]`.
  - `rcnt_r` counts accepted beats. The last beat (`burst_len_p-1`) pops the FIFO and clears `rcnt_r`.
  - Read return proceeds independently of write-FSM state.
- FIFO empty: `mem_rdata_ready_and_o=0` and all `dma_data_v_o=0`. Beats arriving in this state are stalled, never dropped.
- FIFO full: no read packet is granted. Push occurs only on a not-full FIFO, even if a pop happens in the same cycle.
- Simultaneous push and pop (not full) are both honoured.
- Reset mid-burst: all state is discarded.

## Timing
- Packet grant, packet yumi, write-data path and read-data path are combinational (zero latency). All state updates on the `clk_i` edge.
- Reset values:
  - State IDLE; pointer, `wcnt_r` and `rcnt_r` all 0; FIFO empty.
  - All `*_v_o` and `*_yumi_o` are 0 and `mem_rdata_ready_and_o=0` during reset and the first cycle after it unless inputs request.
- `mem_pkt_v_o` never depends on `mem_pkt_ready_and_i`.
- Back-to-back packet grants are allowed every cycle in IDLE.
- Write lock lasts exactly `burst_len_p` accepted beats.

## Configuration
- `BSG_CACHE_DMA_ARBITER_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, and the pointer register is removed.
  - Undefined (default): round-robin as above.

## Test plan
- `num_cache_p=4`, `burst_len_p=2`; caches 0 and 2 issue reads in the same cycle -> grant 0 then 2; 4 returned beats route to cache 0, 0, 2, 2.
- Cache 1 issues a write with beats A,B, and cache 3 requests a read during the burst -> read granted only after beat B is accepted; `mem_wdata_o` shows A,B.
- `read_fifo_els_p=2`, 3 reads pending -> third packet withheld until the first read's last beat pops the FIFO.
- Hold `mem_pkt_ready_and_i=0` for 5 cycles with all `dma_pkt_v_i` set -> grant stable and no yumi; on release the pointer advances by one.
- Assert `mem_rdata_v_i` with an empty FIFO -> `mem_rdata_ready_and_o=0` and no `dma_data_v_o`.
- Assert reset during a write burst at `wcnt_r=1` -> next cycle IDLE, all valids and yumis 0, FIFO empty.

Source files
------------

// File: rtl/bsg_cache_dma_arbiter.sv
// Shares one memory-side DMA channel among num_cache_p cache DMA ports; write bursts lock to their owner.
// Define BSG_CACHE_DMA_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bsg_cache_dma_arbiter #(
    parameter int num_cache_p           = 2,
    parameter int addr_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int ways_p                = 2,
    parameter int dma_data_width_p      = 32,
    parameter int burst_len_p           = 4,
    parameter int read_fifo_els_p       = 4,
    // Packet layout, MSB first: {write_not_read, way_id, mask, addr}
    localparam int way_id_width_lp = (ways_p > 1) ? $clog2(ways_p) : 1,
    localparam int pkt_width_lp    = 1 + way_id_width_lp + block_size_in_words_p + addr_width_p
) (
    input  logic                                            clk_i,
    input  logic                                            reset_i,
    input  logic [num_cache_p-1:0][pkt_width_lp-1:0]        dma_pkt_i,
    input  logic [num_cache_p-1:0]                          dma_pkt_v_i,
    output logic [num_cache_p-1:0]                          dma_pkt_yumi_o,
    input  logic [num_cache_p-1:0][dma_data_width_p-1:0]    dma_data_i,
    input  logic [num_cache_p-1:0]                          dma_data_v_i,
    output logic [num_cache_p-1:0]                          dma_data_yumi_o,
    output logic [num_cache_p-1:0][dma_data_width_p-1:0]    dma_data_o,
    output logic [num_cache_p-1:0]                          dma_data_v_o,
    input  logic [num_cache_p-1:0]                          dma_data_ready_and_i,
    output logic [pkt_width_lp-1:0]                         mem_pkt_o,
    output logic                                            mem_pkt_v_o,
    input  logic                                            mem_pkt_ready_and_i,
    output logic [dma_data_width_p-1:0]                     mem_wdata_o,
    output logic                                            mem_wdata_v_o,
    input  logic                                            mem_wdata_ready_and_i,
    input  logic [dma_data_width_p-1:0]                     mem_rdata_i,
    input  logic                                            mem_rdata_v_i,
    output logic                                            mem_rdata_ready_and_o
);

    localparam int id_width_lp       = $clog2(num_cache_p);
    localparam int cnt_width_lp      = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam int fifo_ptr_width_lp = (read_fifo_els_p > 1) ? $clog2(read_fifo_els_p) : 1;
    localparam int fifo_cnt_width_lp = $clog2(read_fifo_els_p + 1);
    localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(burst_len_p - 1);
    localparam int wnr_bit_lp = pkt_width_lp - 1;

    typedef enum logic {IDLE, SEND_WDATA} state_e;

    state_e                       state_r, state_n;
    logic [id_width_lp-1:0]       wid_r, gnt, start_id, rid;
    logic [cnt_width_lp-1:0]      wcnt_r, rcnt_r;
    logic [id_width_lp-1:0]       fifo_mem_r [read_fifo_els_p];
    logic [fifo_ptr_width_lp-1:0] fifo_wptr_r, fifo_rptr_r;
    logic [fifo_cnt_width_lp-1:0] fifo_cnt_r;
    logic                         fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [num_cache_p-1:0]       eligible;
    logic                         gnt_v, pkt_hs, wdata_hs, rdata_hs;

    assign fifo_full  = (fifo_cnt_r == fifo_cnt_width_lp'(read_fifo_els_p));
    assign fifo_empty = (fifo_cnt_r == '0);
    assign rid        = fifo_mem_r[fifo_rptr_r];

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < 32'(num_cache_p); i++)
            eligible[i] = dma_pkt_v_i[i] & (dma_pkt_i[i][wnr_bit_lp] | ~fifo_full);
    end

    // Scan starts at start_id and wraps, so the first eligible port from there wins.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        gnt   = '0;
        gnt_v = 1'b0;
        for (int unsigned k = 0; k < 32'(num_cache_p); k++) begin
            idx = (32'(start_id) + k) % 32'(num_cache_p);
            if (!gnt_v && eligible[id_width_lp'(idx)]) begin
                gnt   = id_width_lp'(idx);
                gnt_v = 1'b1;
            end
        end
    end

    always_comb begin
        state_n         = state_r;
        mem_pkt_o       = dma_pkt_i[gnt];
        mem_pkt_v_o     = 1'b0;
        dma_pkt_yumi_o  = '0;
        pkt_hs          = 1'b0;
        mem_wdata_o     = dma_data_i[wid_r];
        mem_wdata_v_o   = 1'b0;
        dma_data_yumi_o = '0;
        wdata_hs        = 1'b0;
        case (state_r)
            IDLE: begin
                mem_pkt_v_o         = gnt_v & ~reset_i;
                pkt_hs              = mem_pkt_v_o & mem_pkt_ready_and_i;
                dma_pkt_yumi_o[gnt] = pkt_hs;
                if (pkt_hs && mem_pkt_o[wnr_bit_lp])
                    state_n = SEND_WDATA;
            end
            SEND_WDATA: begin
                mem_wdata_v_o            = dma_data_v_i[wid_r] & ~reset_i;
                wdata_hs                 = mem_wdata_v_o & mem_wdata_ready_and_i;
                dma_data_yumi_o[wid_r]   = wdata_hs;
                if (wdata_hs && (wcnt_r == last_beat_lp))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Fill data is broadcast; only the port at the ID FIFO head sees valid.
    always_comb begin
        dma_data_o            = '0;
        dma_data_v_o          = '0;
        for (int unsigned i = 0; i < 32'(num_cache_p); i++)
            dma_data_o[i] = mem_rdata_i;
        dma_data_v_o[rid]     = mem_rdata_v_i & ~fifo_empty & ~reset_i;
        mem_rdata_ready_and_o = ~fifo_empty & dma_data_ready_and_i[rid] & ~reset_i;
    end

    assign rdata_hs  = mem_rdata_v_i & mem_rdata_ready_and_o;
    assign fifo_push = pkt_hs & ~mem_pkt_o[wnr_bit_lp] & ~fifo_full;
    assign fifo_pop  = rdata_hs & (rcnt_r == last_beat_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= IDLE;
            wid_r       <= '0;
            wcnt_r      <= '0;
            rcnt_r      <= '0;
            fifo_wptr_r <= '0;
            fifo_rptr_r <= '0;
            fifo_cnt_r  <= '0;
        end else begin
            state_r <= state_n;
            if (pkt_hs && mem_pkt_o[wnr_bit_lp]) begin
                wid_r  <= gnt;
                wcnt_r <= '0;
            end else if (wdata_hs) begin
                wcnt_r <= (wcnt_r == last_beat_lp) ? '0 : wcnt_r + 1'b1;
            end
            if (rdata_hs)
                rcnt_r <= (rcnt_r == last_beat_lp) ? '0 : rcnt_r + 1'b1;
            if (fifo_push)
                fifo_wptr_r <= (fifo_wptr_r == fifo_ptr_width_lp'(read_fifo_els_p - 1))
                             ? '0 : fifo_wptr_r + 1'b1;
            if (fifo_pop)
                fifo_rptr_r <= (fifo_rptr_r == fifo_ptr_width_lp'(read_fifo_els_p - 1))
                             ? '0 : fifo_rptr_r + 1'b1;
            if (fifo_push && !fifo_pop)
                fifo_cnt_r <= fifo_cnt_r + 1'b1;
            else if (!fifo_push && fifo_pop)
                fifo_cnt_r <= fifo_cnt_r - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push)
            fifo_mem_r[fifo_wptr_r] <= gnt;
    end

`ifdef BSG_CACHE_DMA_ARBITER_FIXED_PRIO_EN
    assign start_id = '0;
`else
    logic [id_width_lp-1:0] rr_ptr_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            rr_ptr_r <= '0;
        else if (pkt_hs)
            rr_ptr_r <= (gnt == id_width_lp'(num_cache_p - 1)) ? '0 : gnt + 1'b1;
    end

    assign start_id = rr_ptr_r;
`endif

endmodule

// File: tb/tb_bsg_cache_dma_arbiter.sv
// Scoreboard bench for bsg_cache_dma_arbiter: 4 ports, 2-beat bursts, 2-entry read ID FIFO.
`timescale 1ns/1ps
module tb_bsg_cache_dma_arbiter;

    localparam int N  = 4;
    localparam int PW = 1 + 1 + 4 + 8;
    localparam int DW = 16;

    logic                   clk, reset_i;
    logic [N-1:0][PW-1:0]   dma_pkt_i;
    logic [N-1:0]           dma_pkt_v_i, dma_pkt_yumi_o;
    logic [N-1:0][DW-1:0]   dma_data_i, dma_data_o;
    logic [N-1:0]           dma_data_v_i, dma_data_yumi_o, dma_data_v_o, dma_data_ready_and_i;
    logic [PW-1:0]          mem_pkt_o;
    logic                   mem_pkt_v_o, mem_pkt_ready_and_i;
    logic [DW-1:0]          mem_wdata_o, mem_rdata_i;
    logic                   mem_wdata_v_o, mem_wdata_ready_and_i;
    logic                   mem_rdata_v_i, mem_rdata_ready_and_o;

    bsg_cache_dma_arbiter #(
        .num_cache_p(N), .addr_width_p(8), .block_size_in_words_p(4), .ways_p(2),
        .dma_data_width_p(DW), .burst_len_p(2), .read_fifo_els_p(2)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
        .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
        .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_and_i(dma_data_ready_and_i),
        .mem_pkt_o(mem_pkt_o), .mem_pkt_v_o(mem_pkt_v_o), .mem_pkt_ready_and_i(mem_pkt_ready_and_i),
        .mem_wdata_o(mem_wdata_o), .mem_wdata_v_o(mem_wdata_v_o), .mem_wdata_ready_and_i(mem_wdata_ready_and_i),
        .mem_rdata_i(mem_rdata_i), .mem_rdata_v_i(mem_rdata_v_i), .mem_rdata_ready_and_o(mem_rdata_ready_and_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] port; logic [PW-1:0] pkt;  } pkt_exp_t;
    typedef struct packed { logic [1:0] port; logic [DW-1:0] data; } beat_exp_t;

    pkt_exp_t    exp_pkt_q[$];
    beat_exp_t   exp_wd_q[$];
    beat_exp_t   exp_fill_q[$];
    logic [DW-1:0] mrd_q[$];
    logic [DW-1:0] wbeat [N][2];
    int unsigned   widx [N];
    logic          mem_en;
    int            checks, fails;

    logic [N-1:0]  s_pkt_yumi, s_dy, s_dv;
    logic [PW-1:0] s_pkt;
    logic [DW-1:0] s_wd;
    logic          s_pkt_v, s_wd_v, s_rd_rdy, s_rd_hs;

    function automatic logic [PW-1:0] mkpkt(input logic wnr, input logic [PW-2:0] tag);
        return {wnr, tag};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic drive_mem();
        mem_rdata_v_i = mem_en && (mrd_q.size() != 0);
        mem_rdata_i   = (mrd_q.size() != 0) ? mrd_q[0] : '0;
    endtask

    // One clock: sample outputs mid-cycle, then retire whatever the DUT consumed.
    task automatic step();
        @(negedge clk);
        s_pkt_yumi = dma_pkt_yumi_o; s_pkt_v = mem_pkt_v_o; s_pkt = mem_pkt_o;
        s_wd_v = mem_wdata_v_o; s_wd = mem_wdata_o; s_dy = dma_data_yumi_o;
        s_dv = dma_data_v_o; s_rd_rdy = mem_rdata_ready_and_o;
        s_rd_hs = mem_rdata_v_i & mem_rdata_ready_and_o;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_pkt_yumi[i]) dma_pkt_v_i[i] = 1'b0;
            if (s_dy[i]) begin
                widx[i]++;
                if (widx[i] >= 2) dma_data_v_i[i] = 1'b0;
                else dma_data_i[i] = wbeat[i][widx[i]];
            end
        end
        if (s_rd_hs) void'(mrd_q.pop_front());
        drive_mem();
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && (exp_pkt_q.size() + exp_wd_q.size() + exp_fill_q.size()) != 0; n++)
            step();
        chk("drain_outstanding", 32'(exp_pkt_q.size() + exp_wd_q.size() + exp_fill_q.size()), 0);
    endtask

    task automatic start_write(input int p, input logic [PW-2:0] tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
        wbeat[p][0] = a; wbeat[p][1] = b; widx[p] = 0;
        dma_data_i[p] = a; dma_data_v_i[p] = 1'b1;
        dma_pkt_i[p] = mkpkt(1'b1, tag); dma_pkt_v_i[p] = 1'b1;
    endtask

    task automatic start_read(input int p, input logic [PW-2:0] tag);
        dma_pkt_i[p] = mkpkt(1'b0, tag); dma_pkt_v_i[p] = 1'b1;
    endtask

    task automatic monitor();
        pkt_exp_t  ep;
        beat_exp_t eb;
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                if (mem_pkt_v_o && mem_pkt_ready_and_i) begin
                    if (exp_pkt_q.size() == 0) chk("pkt_unexpected", 32'(mem_pkt_o), 0);
                    else begin
                        ep = exp_pkt_q.pop_front();
                        chk("pkt_data", 32'(mem_pkt_o), 32'(ep.pkt));
                        chk("pkt_yumi", 32'(dma_pkt_yumi_o), 32'(4'b1 << ep.port));
                    end
                end
                if (mem_wdata_v_o && mem_wdata_ready_and_i) begin
                    if (exp_wd_q.size() == 0) chk("wdata_unexpected", 32'(mem_wdata_o), 0);
                    else begin
                        eb = exp_wd_q.pop_front();
                        chk("wdata", 32'(mem_wdata_o), 32'(eb.data));
                        chk("wdata_yumi", 32'(dma_data_yumi_o), 32'(4'b1 << eb.port));
                    end
                end
                if ((dma_data_v_o & dma_data_ready_and_i) != '0) begin
                    if (exp_fill_q.size() == 0) chk("fill_unexpected", 32'(dma_data_v_o), 0);
                    else begin
                        eb = exp_fill_q.pop_front();
                        chk("fill_port", 32'(dma_data_v_o), 32'(4'b1 << eb.port));
                        chk("fill_data", 32'(dma_data_o[eb.port]), 32'(eb.data));
                        chk("fill_mem_ready", 32'(mem_rdata_ready_and_o), 1);
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0; fails = 0;
        reset_i = 1'b1; mem_en = 1'b0;
        dma_pkt_i = '0; dma_pkt_v_i = '0; dma_data_i = '0; dma_data_v_i = '0;
        dma_data_ready_and_i = '1; mem_pkt_ready_and_i = 1'b1;
        mem_wdata_ready_and_i = 1'b1; mem_rdata_i = '0; mem_rdata_v_i = 1'b0;
        for (int i = 0; i < N; i++) widx[i] = 0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL global_timeout: simulation did not finish");
                $fatal(1, "timeout");
            end
        join_none

        // Reset state
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_pkt_v", 32'(s_pkt_v), 0);
            chk("rst_outputs", 32'({s_pkt_yumi, s_dy, s_dv, s_wd_v, s_rd_rdy}), 0);
        end
        reset_i = 1'b0;
        step();
        chk("post_rst_outputs", 32'({s_pkt_v, s_pkt_yumi, s_dy, s_dv, s_wd_v, s_rd_rdy}), 0);

        // Read beat with empty ID FIFO is stalled, not dropped
        mrd_q.push_back(16'h1000); mem_en = 1'b1; drive_mem();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("empty_rd_ready", 32'(s_rd_rdy), 0);
            chk("empty_fill_v", 32'(s_dv), 0);
        end

        // Reads from 0 and 2 together: grant 0 then 2, beats route 0,0,2,2
        start_read(0, 13'h11); start_read(2, 13'h22);
        exp_pkt_q.push_back({2'd0, mkpkt(1'b0, 13'h11)});
        exp_pkt_q.push_back({2'd2, mkpkt(1'b0, 13'h22)});
        exp_fill_q.push_back({2'd0, 16'h1000}); exp_fill_q.push_back({2'd0, 16'h1001});
        exp_fill_q.push_back({2'd2, 16'h1002}); exp_fill_q.push_back({2'd2, 16'h1003});
        mrd_q.push_back(16'h1001); mrd_q.push_back(16'h1002); mrd_q.push_back(16'h1003);
        step(); chk("rr_first_grant", 32'(s_pkt_yumi), 32'h1);
        step(); chk("rr_second_grant", 32'(s_pkt_yumi), 32'h4);
        drain();

        // Write burst from 1 locks the channel; read from 3 waits for beat B
        mem_wdata_ready_and_i = 1'b0;
        start_write(1, 13'h33, 16'hAAAA, 16'hBBBB);
        exp_pkt_q.push_back({2'd1, mkpkt(1'b1, 13'h33)});
        exp_pkt_q.push_back({2'd3, mkpkt(1'b0, 13'h44)});
        exp_wd_q.push_back({2'd1, 16'hAAAA}); exp_wd_q.push_back({2'd1, 16'hBBBB});
        exp_fill_q.push_back({2'd3, 16'h2000}); exp_fill_q.push_back({2'd3, 16'h2001});
        step(); chk("wr_grant", 32'(s_pkt_yumi), 32'h2);
        start_read(3, 13'h44);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("lock_no_pkt", 32'(s_pkt_v), 0);
            chk("lock_wdata_v", 32'(s_wd_v), 1);
            chk("lock_wdata_hold", 32'(s_wd), 32'hAAAA);
            chk("lock_no_yumi", 32'(s_dy), 0);
        end
        mem_wdata_ready_and_i = 1'b1;
        step(); chk("beatA_no_pkt", 32'(s_pkt_v), 0); chk("beatA_yumi", 32'(s_dy), 32'h2);
        step(); chk("beatB_no_pkt", 32'(s_pkt_v), 0); chk("beatB_data", 32'(s_wd), 32'hBBBB);
        step(); chk("read_after_burst", 32'(s_pkt_yumi), 32'h8);
        mrd_q.push_back(16'h2000); mrd_q.push_back(16'h2001); drive_mem();
        drain();

        // FIFO full: third read withheld until first read's last beat pops
        mem_en = 1'b0; drive_mem();
        start_read(0, 13'h50); start_read(1, 13'h51); start_read(2, 13'h52);
        exp_pkt_q.push_back({2'd0, mkpkt(1'b0, 13'h50)});
        exp_pkt_q.push_back({2'd1, mkpkt(1'b0, 13'h51)});
        exp_pkt_q.push_back({2'd2, mkpkt(1'b0, 13'h52)});
        for (int i = 0; i < 6; i++) exp_fill_q.push_back({2'(i / 2), 16'(16'h3000 + i)});
        step(); chk("full_grant0", 32'(s_pkt_yumi), 32'h1);
        step(); chk("full_grant1", 32'(s_pkt_yumi), 32'h2);
        for (int c = 0; c < 3; c++) begin step(); chk("full_withheld", 32'(s_pkt_v), 0); end
        for (int i = 0; i < 6; i++) mrd_q.push_back(16'(16'h3000 + i));
        mem_en = 1'b1; drive_mem();
        step(); chk("full_first_beat", 32'(s_pkt_v), 0);
        step(); chk("full_last_beat", 32'(s_pkt_v), 0);
        step(); chk("full_grant2", 32'(s_pkt_yumi), 32'h4);
        drain();

        // Back-pressure: grant stable, no yumi; pointer advances by one on release
        mem_pkt_ready_and_i = 1'b0;
        for (int i = 0; i < N; i++) start_read(i, 13'(13'h60 + i));
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_pkt_v", 32'(s_pkt_v), 1);
            chk("bp_pkt_stable", 32'(s_pkt), 32'(mkpkt(1'b0, 13'h63)));
            chk("bp_no_yumi", 32'(s_pkt_yumi), 0);
        end
        exp_pkt_q.push_back({2'd3, mkpkt(1'b0, 13'h63)});
        exp_pkt_q.push_back({2'd0, mkpkt(1'b0, 13'h60)});
        exp_pkt_q.push_back({2'd1, mkpkt(1'b0, 13'h61)});
        exp_pkt_q.push_back({2'd2, mkpkt(1'b0, 13'h62)});
        mem_pkt_ready_and_i = 1'b1;
        step(); chk("bp_release", 32'(s_pkt_yumi), 32'h8);
        step(); chk("bp_next", 32'(s_pkt_yumi), 32'h1);
        for (int i = 0; i < 8; i++) begin
            exp_fill_q.push_back({2'((i / 2 + 3) % 4), 16'(16'h4000 + i)});
            mrd_q.push_back(16'(16'h4000 + i));
        end
        drive_mem();
        drain();

        // Reset mid-burst after beat C (wcnt_r=1) with a read outstanding
        start_read(2, 13'h70);
        exp_pkt_q.push_back({2'd2, mkpkt(1'b0, 13'h70)});
        step(); chk("pre_rst_read", 32'(s_pkt_yumi), 32'h4);
        start_write(0, 13'h71, 16'hCCCC, 16'hDDDD);
        exp_pkt_q.push_back({2'd0, mkpkt(1'b1, 13'h71)});
        exp_wd_q.push_back({2'd0, 16'hCCCC});
        step(); chk("pre_rst_write", 32'(s_pkt_yumi), 32'h1);
        step(); chk("pre_rst_beatC", 32'(s_dy), 32'h1);
        reset_i = 1'b1;
        step(); chk("mid_rst_outputs", 32'({s_pkt_v, s_wd_v, s_dy, s_dv, s_rd_rdy}), 0);
        reset_i = 1'b0;
        mrd_q.push_back(16'h5000); drive_mem();
        step();
        chk("after_rst_wdata_v", 32'(s_wd_v), 0);
        chk("after_rst_yumis", 32'({s_pkt_v, s_pkt_yumi, s_dy}), 0);
        chk("after_rst_fifo_empty", 32'({s_rd_rdy, s_dv}), 0);
        dma_data_v_i[0] = 1'b0;
        start_read(0, 13'h81); start_read(1, 13'h80);
        exp_pkt_q.push_back({2'd0, mkpkt(1'b0, 13'h81)});
        exp_pkt_q.push_back({2'd1, mkpkt(1'b0, 13'h80)});
        for (int i = 0; i < 4; i++) exp_fill_q.push_back({2'(i / 2), 16'(16'h5000 + i)});
        for (int i = 1; i < 4; i++) mrd_q.push_back(16'(16'h5000 + i));
        step(); chk("rst_ptr_grant0", 32'(s_pkt_yumi), 32'h1);
        step(); chk("rst_ptr_grant1", 32'(s_pkt_yumi), 32'h2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
